// File: rtl/afe_udma_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : afe_udma_mc_if
// Description : Multi-channel AFE readout-to-uDMA bridge. Arbitrates N_CH
//               readout buffers round-robin, fetches one word per grant
//               (IDLE -> SAMPLE) and pushes {channel, address, data} into a
//               FIFO_DEPTH-entry FIFO that feeds the uDMA RX channel.
// Revision    : 1.0 - initial multi-channel release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1          clock
//   rstn_i         in   1          asynchronous reset, active-low
//   ro_valid_i     in   N_CH       channel c buffer holds data
//   ro_buf_ce_o    out  N_CH       buffer read enable, one-hot or zero
//   ro_vtransfer_o out  N_CH       word consumed, one-hot or zero
//   ro_rdata_i     in   N_CH*DW    packed data, channel c at [c*DW +: DW]
//   ro_raddr_i     in   N_CH*AW    packed address, channel c at [c*AW +: AW]
//   udma_shtdwn_i  in   1          uDMA shutdown, blocks new grants
//   udma_ready_i   in   1          uDMA accepts the head word
//   udma_valid_o   out  1          FIFO head valid
//   udma_wdata_o   out  DW         FIFO head data
//   udma_waddr_o   out  AW         FIFO head address
//   udma_ch_o      out  CW         FIFO head channel index
//   busy_o         out  1          FSM not IDLE or FIFO non-empty
// Configuration macro
//   AFE_UDMA_CH_TAG_EN : when defined, the top CW bits of udma_waddr_o carry
//                        the head channel index so each channel owns its own
//                        L2 region. Ports are identical in both builds.
// ============================================================================
module afe_udma_mc_if #(
  parameter int N_CH           = 4,
  parameter int L2_DATA_WIDTH  = 32,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int FIFO_DEPTH     = 4,
  localparam int CW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [N_CH-1:0]                    ro_valid_i,
  output logic [N_CH-1:0]                    ro_buf_ce_o,
  output logic [N_CH-1:0]                    ro_vtransfer_o,
  input  logic [N_CH*L2_DATA_WIDTH-1:0]      ro_rdata_i,
  input  logic [N_CH*L2_AWIDTH_NOAL-1:0]     ro_raddr_i,
  input  logic                               udma_shtdwn_i,
  input  logic                               udma_ready_i,
  output logic                               udma_valid_o,
  output logic [L2_DATA_WIDTH-1:0]           udma_wdata_o,
  output logic [L2_AWIDTH_NOAL-1:0]          udma_waddr_o,
  output logic [CW-1:0]                      udma_ch_o,
  output logic                               busy_o
);

  localparam int DW = L2_DATA_WIDTH;
  localparam int AW = L2_AWIDTH_NOAL;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SAMPLE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                         state_q, state_d;
  logic [CW-1:0]                  grant_ch_q, grant_ch_d;
  logic [CW-1:0]                  rr_ptr_q, rr_ptr_d;

  logic [FIFO_DEPTH-1:0][DW-1:0]  data_mem_q, data_mem_d;
  logic [FIFO_DEPTH-1:0][AW-1:0]  addr_mem_q, addr_mem_d;
  logic [FIFO_DEPTH-1:0][CW-1:0]  ch_mem_q, ch_mem_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [PW:0]                    cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Round-robin winner search: first valid channel at or after rr_ptr_q,
  // wrapping. Written with an explicit wrap so non power-of-2 N_CH works.
  // --------------------------------------------------------------------------
  logic          any_valid;
  logic [CW-1:0] win_ch;

  always_comb begin
    any_valid = 1'b0;
    win_ch    = '0;
    for (int i = 0; i < N_CH; i++) begin
      int idx;
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      if (!any_valid && ro_valid_i[idx]) begin
        any_valid = 1'b1;
        win_ch    = CW'(idx);
      end
    end
  end

  // rstn_i is folded in so a channel held valid during reset cannot raise a
  // read enable while the bridge is being held in reset.
  logic fifo_full;
  logic grant_ok;

  assign fifo_full = (cnt_q == FULL_CNT);
  assign grant_ok  = rstn_i & any_valid & ~udma_shtdwn_i & ~fifo_full;

  // --------------------------------------------------------------------------
  // FSM next state and buffer-side outputs
  // --------------------------------------------------------------------------
  logic push;

  always_comb begin
    state_d        = state_q;
    grant_ch_d     = grant_ch_q;
    rr_ptr_d       = rr_ptr_q;
    ro_buf_ce_o    = '0;
    ro_vtransfer_o = '0;
    push           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_ok) begin
          ro_buf_ce_o[win_ch] = 1'b1;
          grant_ch_d          = win_ch;
          rr_ptr_d            = (win_ch == LAST_CH) ? '0 : win_ch + 1'b1;
          state_d             = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // The space check made at grant time reserves the slot, so this push
        // is unconditional even if the channel dropped valid or shutdown rose.
        ro_buf_ce_o[grant_ch_q]    = 1'b1;
        ro_vtransfer_o[grant_ch_q] = 1'b1;
        push                       = 1'b1;
        state_d                    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic pop;

  assign udma_valid_o = (cnt_q != '0);
  assign pop          = udma_valid_o & udma_ready_i;

  always_comb begin
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;
    ch_mem_d   = ch_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (push) begin
      data_mem_d[wr_ptr_q] = ro_rdata_i[int'(grant_ch_q)*DW +: DW];
      addr_mem_d[wr_ptr_q] = ro_raddr_i[int'(grant_ch_q)*AW +: AW];
      ch_mem_d[wr_ptr_q]   = grant_ch_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      grant_ch_q <= '0;
      rr_ptr_q   <= '0;
      data_mem_q <= '0;
      addr_mem_q <= '0;
      ch_mem_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      data_mem_q <= data_mem_d;
      addr_mem_q <= addr_mem_d;
      ch_mem_q   <= ch_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // uDMA-side outputs: the head entry comes straight from storage flops, so
  // there is no combinational path from the readout inputs. Storage is reset
  // to zero, which keeps the head outputs at zero while the FIFO is empty
  // after reset.
  // --------------------------------------------------------------------------
  logic [AW-1:0] head_addr;

  assign head_addr    = addr_mem_q[rd_ptr_q];
  assign udma_wdata_o = data_mem_q[rd_ptr_q];
  assign udma_ch_o    = ch_mem_q[rd_ptr_q];
  assign busy_o       = (state_q != ST_IDLE) | udma_valid_o;

`ifdef AFE_UDMA_CH_TAG_EN
  // Channel index replaces the top address bits; the stored upper bits are
  // intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^head_addr[AW-1 -: CW];
  assign udma_waddr_o     = {udma_ch_o, head_addr[AW-CW-1:0]};
`else
  assign udma_waddr_o     = head_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_afe_udma_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_afe_udma_mc_if
// Description : Self-checking bench for afe_udma_mc_if. A cycle model of the
//               arbiter/FIFO predicts the read enables each cycle and pushes
//               expected {ch, addr, data} entries to a scoreboard queue; the
//               FIFO head is compared against the queue front while valid and
//               popped on handshake. Directed scenarios cover single channel,
//               contention, back-pressure, shutdown, reset and address tagging.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afe_udma_mc_if;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int D   = 4;
  localparam int CW  = 2;
  localparam int INF = 1000000;

  logic              clk_i;
  logic              rstn_i;
  logic [N-1:0]      ro_valid_i;
  logic [N-1:0]      ro_buf_ce_o;
  logic [N-1:0]      ro_vtransfer_o;
  logic [N*DW-1:0]   ro_rdata_i;
  logic [N*AW-1:0]   ro_raddr_i;
  logic              udma_shtdwn_i;
  logic              udma_ready_i;
  logic              udma_valid_o;
  logic [DW-1:0]     udma_wdata_o;
  logic [AW-1:0]     udma_waddr_o;
  logic [CW-1:0]     udma_ch_o;
  logic              busy_o;

  afe_udma_mc_if #(
    .N_CH           (N),
    .L2_DATA_WIDTH  (DW),
    .L2_AWIDTH_NOAL (AW),
    .FIFO_DEPTH     (D)
  ) u_dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .ro_valid_i     (ro_valid_i),
    .ro_buf_ce_o    (ro_buf_ce_o),
    .ro_vtransfer_o (ro_vtransfer_o),
    .ro_rdata_i     (ro_rdata_i),
    .ro_raddr_i     (ro_raddr_i),
    .udma_shtdwn_i  (udma_shtdwn_i),
    .udma_ready_i   (udma_ready_i),
    .udma_valid_o   (udma_valid_o),
    .udma_wdata_o   (udma_wdata_o),
    .udma_waddr_o   (udma_waddr_o),
    .udma_ch_o      (udma_ch_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Counters and scoreboard
  int               n_vec = 0;
  int               n_err = 0;
  int               n_grants = 0;
  int               n_pops = 0;
  int               glog[$];
  logic [45:0]      sb[$];

  // Readout buffer model: remaining words, word counter, base address
  int               rem  [N];
  int               wcnt [N];
  int               base [N];

  // Reference model state
  int               m_state = 0;   // 0 = IDLE, 1 = SAMPLE
  int               m_g     = 0;
  int               m_rr    = 0;
  int               m_cnt   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] tag_addr(input int ch, input logic [AW-1:0] a);
`ifdef AFE_UDMA_CH_TAG_EN
    return {2'(ch), a[AW-CW-1:0]};
`else
    return a;
`endif
  endfunction

  task automatic drive_bufs();
    for (int c = 0; c < N; c++) begin
      ro_valid_i[c]            = (rem[c] > 0);
      ro_rdata_i[c*DW +: DW]   = {8'(8'hA0 + c), 24'(wcnt[c])};
      ro_raddr_i[c*AW +: AW]   = AW'(base[c] + wcnt[c]);
    end
  endtask

  // One clock cycle: evaluate model and compare at the falling edge, then
  // advance the buffer model just after the rising edge.
  task automatic cycle();
    logic [N-1:0] ece, evt, gmask, vt_seen;
    logic [45:0]  ent;
    bit           push, pop, granted;
    int           w;
    @(negedge clk_i);
    ece = '0; evt = '0; push = 0; pop = 0; granted = 0; w = -1; ent = '0;
    if (!rstn_i) begin
      m_state = 0; m_rr = 0; m_cnt = 0; m_g = 0;
      sb.delete();
    end else if (m_state == 0) begin
      if (!udma_shtdwn_i && m_cnt < D) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
          if (w < 0 && rem[k] > 0) w = k;
        end
        if (w >= 0) begin
          ece[w] = 1'b1; m_g = w; m_rr = (w + 1) % N; granted = 1;
        end
      end
    end else begin
      ece[m_g] = 1'b1; evt[m_g] = 1'b1; push = 1;
      ent = {2'(m_g), tag_addr(m_g, AW'(base[m_g] + wcnt[m_g])), 8'(8'hA0 + m_g), 24'(wcnt[m_g])};
    end

    check_eq("ce_vt", {ro_buf_ce_o, ro_vtransfer_o}, {ece, evt});
    check_eq("valid", udma_valid_o, (m_cnt != 0));
    check_eq("busy", busy_o, (m_state != 0) || (m_cnt != 0));

    if (udma_valid_o) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        check_eq("head", {udma_ch_o, udma_waddr_o, udma_wdata_o}, sb[0]);
        if (udma_ready_i) begin
          void'(sb.pop_front());
          n_pops++;
        end
      end
    end
    if (rstn_i) begin
      pop = (m_cnt != 0) && udma_ready_i;
      if (push) sb.push_back(ent);
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_state = (m_state == 0) ? int'(granted) : 0;
    end

    gmask = ro_buf_ce_o & ~ro_vtransfer_o;
    for (int c = 0; c < N; c++) begin
      if (gmask[c]) begin
        glog.push_back(c);
        n_grants++;
      end
    end
    vt_seen = ro_vtransfer_o;

    @(posedge clk_i);
    #1;
    for (int c = 0; c < N; c++) begin
      if (vt_seen[c]) begin
        wcnt[c]++;
        if (rem[c] > 0 && rem[c] != INF) rem[c]--;
      end
    end
    drive_bufs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic stop_all();
    for (int c = 0; c < N; c++) rem[c] = 0;
    drive_bufs();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((m_cnt != 0 || m_state != 0) && k < 60) begin
      cycle();
      k++;
    end
    if (k >= 60) check_eq({tag, "_timeout"}, 1, 0);
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic reset_dut();
    rstn_i = 1'b0;
    run(2);
    rstn_i = 1'b1;
  endtask

  int exp_a[4] = '{0, 2, 0, 2};
  int exp_b[6] = '{3, 0, 2, 3, 0, 2};

  initial begin
    int k;
    rstn_i = 1'b1; udma_shtdwn_i = 1'b0; udma_ready_i = 1'b0;
    for (int c = 0; c < N; c++) begin
      rem[c] = 0; wcnt[c] = 0; base[c] = 16 * (c + 1);
    end
    drive_bufs();
    #1 rstn_i = 1'b0;
    #1;
    // Reset state
    check_eq("rst_ce", ro_buf_ce_o, 0);
    check_eq("rst_vt", ro_vtransfer_o, 0);
    check_eq("rst_valid", udma_valid_o, 0);
    check_eq("rst_data", udma_wdata_o, 0);
    check_eq("rst_addr", udma_waddr_o, 0);
    check_eq("rst_ch", udma_ch_o, 0);
    check_eq("rst_busy", busy_o, 0);
    run(2);
    rstn_i = 1'b1;
    run(1);

    // T1: single channel, 3 words, 2-cycle latency
    udma_ready_i = 1'b1; n_pops = 0;
    rem[1] = 3; drive_bufs();
    cycle();
    check_eq("t1_lat1", udma_valid_o, 0);
    cycle();
    check_eq("t1_lat2", udma_valid_o, 1);
    run(6);
    drain("t1");
    check_eq("t1_pops", n_pops, 3);

    // T2: contention, starting from a fresh RR pointer
    reset_dut();
    rem[0] = INF; rem[2] = INF; drive_bufs();
    glog.delete();
    run(8);
    check_eq("t2a_cnt", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check_eq("t2a_order", glog[i], exp_a[i]);
    rem[3] = INF; drive_bufs();
    glog.delete();
    run(12);
    check_eq("t2b_cnt", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) check_eq("t2b_order", glog[i], exp_b[i]);
    stop_all();
    drain("t2");

    // T3: back-pressure, exactly FIFO_DEPTH grants then resume
    udma_ready_i = 1'b0; n_grants = 0;
    rem[0] = INF; drive_bufs();
    run(20);
    check_eq("t3_full_grants", n_grants, D);
    check_eq("t3_valid_held", udma_valid_o, 1);
    udma_ready_i = 1'b1; n_grants = 0;
    run(12);
    check_eq("t3_resume", (n_grants >= 4), 1);
    stop_all();
    drain("t3");

    // T4: shutdown raised in the SAMPLE cycle
    rem[1] = INF; drive_bufs();
    k = 0;
    while (m_state != 1 && k < 10) begin cycle(); k++; end
    if (k >= 10) check_eq("t4_wait_timeout", 1, 0);
    udma_shtdwn_i = 1'b1; n_grants = 0; n_pops = 0;
    run(10);
    check_eq("t4_no_grant", n_grants, 0);
    check_eq("t4_busy", busy_o, 0);
    check_eq("t4_sb_empty", sb.size(), 0);
    check_eq("t4_delivered", (n_pops >= 1), 1);
    udma_shtdwn_i = 1'b0;
    stop_all();

    // T5: reset with 3 queued entries and a SAMPLE in flight
    udma_ready_i = 1'b0;
    rem[0] = INF; drive_bufs();
    k = 0;
    while (!(m_cnt == 3 && m_state == 1) && k < 20) begin cycle(); k++; end
    if (k >= 20) check_eq("t5_wait_timeout", 1, 0);
    rstn_i = 1'b0;
    #1;
    check_eq("t5_ce", ro_buf_ce_o, 0);
    check_eq("t5_vt", ro_vtransfer_o, 0);
    check_eq("t5_valid", udma_valid_o, 0);
    check_eq("t5_data", udma_wdata_o, 0);
    check_eq("t5_addr", udma_waddr_o, 0);
    check_eq("t5_ch", udma_ch_o, 0);
    check_eq("t5_busy", busy_o, 0);
    rem[0] = 0; rem[1] = INF; rem[3] = INF; drive_bufs();
    run(2);
    rstn_i = 1'b1;
    glog.delete();
    run(2);
    check_eq("t5_first_cnt", (glog.size() >= 1), 1);
    if (glog.size() >= 1) check_eq("t5_first_grant", glog[0], 1);
    udma_ready_i = 1'b1;
    stop_all();
    drain("t5");

    // T6: address tagging on channel 3
    base[3] = 5; wcnt[3] = 0; rem[3] = 1; drive_bufs();
    k = 0;
    while (!udma_valid_o && k < 10) begin cycle(); k++; end
    if (k >= 10) check_eq("t6_wait_timeout", 1, 0);
    check_eq("t6_ch", udma_ch_o, 3);
`ifdef AFE_UDMA_CH_TAG_EN
    check_eq("t6_waddr", udma_waddr_o, 12'hC05);
`else
    check_eq("t6_waddr", udma_waddr_o, 12'h005);
`endif
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
